// File: rtl/soc_system_nios2_gen2_cpu_mul_pipe_pkg.sv
// Shared definitions for the Nios II two-stage multiplier pipe.
package soc_system_nios2_mul_pkg;

    localparam int unsigned MUL_OP_W = 2;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULXUU = 2'd1,
        MUL_OP_MULXSU = 2'd2,
        MUL_OP_MULXSS = 2'd3
    } mul_op_e;

endpackage

// File: rtl/soc_system_nios2_gen2_cpu_mul_pipe_if.sv
// Valid/ready request and result channels of the multiplier pipe.
interface soc_system_nios2_gen2_cpu_mul_pipe_if
    import soc_system_nios2_mul_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [MUL_OP_W-1:0] in_op;
    logic [DATA_W-1:0]   in_src1;
    logic [DATA_W-1:0]   in_src2;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_result;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/soc_system_nios2_gen2_cpu_mul_pipe_pp_stage.sv
// Stage 1: four registered unsigned half-width partial products.
module soc_system_nios2_mul_pp_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] ll,
    output logic [DATA_W-1:0] lh,
    output logic [DATA_W-1:0] hl,
    output logic [DATA_W-1:0] hh
);
    localparam int unsigned H = DATA_W / 2;

    logic [H-1:0] a_lo, a_hi, b_lo, b_hi;

    assign a_lo = a[H-1:0];
    assign a_hi = a[DATA_W-1:H];
    assign b_lo = b[H-1:0];
    assign b_hi = b[DATA_W-1:H];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ll <= '0;
            lh <= '0;
            hl <= '0;
            hh <= '0;
        end else if (en) begin
            ll <= DATA_W'(a_lo) * DATA_W'(b_lo);
            lh <= DATA_W'(a_lo) * DATA_W'(b_hi);
            hl <= DATA_W'(a_hi) * DATA_W'(b_lo);
            hh <= DATA_W'(a_hi) * DATA_W'(b_hi);
        end
    end
endmodule

// File: rtl/soc_system_nios2_gen2_cpu_mul_pipe.sv
// Two-stage handshaked DATA_W x DATA_W multiplier with high-word modes and flush.
module soc_system_nios2_gen2_cpu_mul_pipe
    import soc_system_nios2_mul_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input logic clk,
    input logic reset_n,
    input logic flush,
    soc_system_nios2_gen2_cpu_mul_pipe_if.slave bus
);
    localparam int unsigned H  = DATA_W / 2;
    localparam int unsigned PW = 2 * DATA_W;

    logic              s1_valid, s2_valid, s1_adv, accept;
    mul_op_e           s1_op;
    logic [TAG_W-1:0]  s1_tag, s2_tag;
    logic [DATA_W-1:0] s1_a, s1_b;
    logic              s1_a_sign;
    logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [DATA_W:0]   mid;
    logic [PW-1:0]     prod;
    logic [DATA_W-1:0] hi, corr_a, corr_b, sel_c, s2_result;

    // Stage 1 moves on whenever stage 2 is empty or being drained this cycle.
    assign s1_adv       = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !flush && (!s1_valid || s1_adv);
    assign accept       = bus.in_valid && bus.in_ready;

    soc_system_nios2_mul_pp_stage #(.DATA_W(DATA_W)) u_pp (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .a       (bus.in_src1),
        .b       (bus.in_src2),
        .ll      (pp_ll),
        .lh      (pp_lh),
        .hl      (pp_hl),
        .hh      (pp_hh)
    );

    // Stage-1 control and sideband registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= MUL_OP_MUL;
            s1_tag    <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_a_sign <= 1'b0;
        end else begin
            if (flush)       s1_valid <= 1'b0;
            else if (accept) s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;
            if (accept) begin
                s1_op     <= mul_op_e'(bus.in_op);
                s1_tag    <= bus.in_tag;
                s1_a      <= bus.in_src1;
                s1_b      <= bus.in_src2;
                s1_a_sign <= bus.in_src1[DATA_W-1];
            end
        end
    end

    // Adder tree keeps the middle-sum carry; high word gets signed correction.
    always_comb begin
        mid    = (DATA_W+1)'(pp_lh) + (DATA_W+1)'(pp_hl);
        prod   = {pp_hh, pp_ll} + (PW'(mid) << H);
        hi     = prod[PW-1:DATA_W];
        corr_a = s1_a_sign ? s1_b : '0;
        corr_b = s1_b[DATA_W-1] ? s1_a : '0;
        sel_c  = prod[DATA_W-1:0];
        case (s1_op)
            MUL_OP_MUL:    sel_c = prod[DATA_W-1:0];
            MUL_OP_MULXUU: sel_c = hi;
            MUL_OP_MULXSU: sel_c = hi - corr_a;
            MUL_OP_MULXSS: sel_c = hi - corr_a - corr_b;
            default:       sel_c = prod[DATA_W-1:0];
        endcase
    end

    // Stage-2 output registers; data is held while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else begin
            if (flush)              s2_valid <= 1'b0;
            else if (s1_adv)        s2_valid <= 1'b1;
            else if (bus.out_ready) s2_valid <= 1'b0;
            if (s1_adv && !flush) begin
                s2_result <= sel_c;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.out_tag    = s2_tag;
endmodule

// File: tb/tb_soc_system_nios2_gen2_cpu_mul_pipe.sv
// Directed and model-checked bench for the two-stage multiplier pipe.
module tb_soc_system_nios2_gen2_cpu_mul_pipe;
    import soc_system_nios2_mul_pkg::*;

    logic clk;
    logic reset_n;
    logic flush;
    int   total;
    int   bad;

    soc_system_nios2_gen2_cpu_mul_pipe_if #(.DATA_W(32), .TAG_W(5)) bus32 ();
    soc_system_nios2_gen2_cpu_mul_pipe_if #(.DATA_W(16), .TAG_W(5)) bus16 ();

    soc_system_nios2_gen2_cpu_mul_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus32.slave)
    );
    soc_system_nios2_gen2_cpu_mul_pipe #(.DATA_W(16), .TAG_W(5)) dut16 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus16.slave)
    );

    always #5 clk = ~clk;

    // Reference: widen operands with the requested signedness, full multiply, pick a word.
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
        logic [127:0] mask, ea, eb, pr;
        mask = (128'd1 << w) - 128'd1;
        ea = 128'(a) & mask;
        eb = 128'(b) & mask;
        if ((op == 2'd2 || op == 2'd3) && a[w-1]) ea = ea | ~mask;
        if (op == 2'd3 && b[w-1]) eb = eb | ~mask;
        pr = ea * eb;
        if (op == 2'd0) return 64'(pr & mask);
        return 64'((pr >> w) & mask);
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return mask;
            3: return 64'd1 << (w - 1);
            4: return mask >> 1;
            default: return {32'($urandom), 32'($urandom)} & mask;
        endcase
    endfunction

    task automatic drive32(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
        bus32.in_valid = v;
        bus32.in_op    = op;
        bus32.in_src1  = a;
        bus32.in_src2  = b;
        bus32.in_tag   = tag;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid); end
        total++; if (bus32.out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result: got %h want 0", bus32.out_result); end
        total++; if (bus32.out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", bus32.out_tag); end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready); end
        reset_n = 1'b1;
    endtask

    // Op presented in cycle k shows its result in cycle k+2.
    task automatic test_back_to_back;
        logic [31:0] exp_r [4] = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 6) begin
                total++; if (bus32.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k - 2, bus32.out_valid); end
                total++; if (bus32.out_result !== exp_r[k-2]) begin bad++; $display("FAIL b2b_result[%0d]: got %h want %h", k - 2, bus32.out_result, exp_r[k-2]); end
                total++; if (bus32.out_tag !== 5'(k - 1)) begin bad++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", k - 2, bus32.out_tag, k - 1); end
            end
            if (k == 6) begin
                total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", bus32.out_valid); end
            end
            if (k < 4) drive32(1'b1, 2'(k), 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(k + 1));
            else       drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        end
    endtask

    task automatic test_corners;
        logic [1:0]  ops [6] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [31:0] va  [6] = '{32'h80000000, 32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF};
        logic [31:0] vb  [6] = '{32'h80000000, 32'h00010000, 32'h00000002, 32'h00000005, 32'h00010001, 32'h00000002};
        logic [31:0] ex  [6] = '{32'h40000000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                total++; if (bus32.out_valid !== 1'b1 || bus32.out_result !== ex[k-2]) begin
                    bad++; $display("FAIL corner[%0d]: got v=%b r=%h want v=1 r=%h", k - 2, bus32.out_valid, bus32.out_result, ex[k-2]);
                end
            end
            if (k < 6) drive32(1'b1, ops[k], va[k], vb[k], 5'(k));
            else       drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int acc = 0;
        bus32.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive32(1'b1, 2'd0, 32'(10 + acc), 32'd3, 5'(acc + 1));
            #1;
            if (bus32.in_ready) acc++;
        end
        total++; if (acc != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", acc); end
        total++; if (bus32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus32.in_ready); end
        total++; if (bus32.out_valid !== 1'b1 || bus32.out_result !== 32'd30 || bus32.out_tag !== 5'd1) begin
            bad++; $display("FAIL bp_stall_hold: got v=%b r=%0d t=%0d want v=1 r=30 t=1", bus32.out_valid, bus32.out_result, bus32.out_tag);
        end
        @(negedge clk);
        drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        total++; if (bus32.out_result !== 32'd30 || bus32.out_tag !== 5'd1) begin
            bad++; $display("FAIL bp_drain1: got r=%0d t=%0d want r=30 t=1", bus32.out_result, bus32.out_tag);
        end
        bus32.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus32.out_valid !== 1'b1 || bus32.out_result !== 32'd33 || bus32.out_tag !== 5'd2) begin
            bad++; $display("FAIL bp_drain2: got v=%b r=%0d t=%0d want v=1 r=33 t=2", bus32.out_valid, bus32.out_result, bus32.out_tag);
        end
        @(negedge clk);
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", bus32.out_valid); end
    endtask

    task automatic test_flush;
        bus32.out_ready = 1'b0;
        @(negedge clk); drive32(1'b1, 2'd0, 32'd7, 32'd6, 5'd7);
        @(negedge clk); drive32(1'b1, 2'd0, 32'd8, 32'd6, 5'd8);
        @(negedge clk);
        total++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 5'd7) begin
            bad++; $display("FAIL flush_prefill: got v=%b t=%0d want v=1 t=7", bus32.out_valid, bus32.out_tag);
        end
        flush = 1'b1;
        drive32(1'b1, 2'd0, 32'd9, 32'd9, 5'd9);
        #1;
        total++; if (bus32.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", bus32.in_ready); end
        @(negedge clk);
        flush = 1'b0;
        drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL flush_cleared: got %b want 0", bus32.out_valid); end
        bus32.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale[%0d]: got v=%b t=%0d want v=0", k, bus32.out_valid, bus32.out_tag); end
        end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_back: got %b want 1", bus32.in_ready); end
    endtask

    task automatic test_async_reset;
        bus32.out_ready = 1'b1;
        @(negedge clk); drive32(1'b1, 2'd0, 32'd2, 32'd2, 5'd4);
        @(negedge clk); drive32(1'b1, 2'd0, 32'd4, 32'd4, 5'd5);
        @(negedge clk); drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        total++; if (bus32.out_valid !== 1'b1 || bus32.out_result !== 32'd4) begin
            bad++; $display("FAIL arst_pre: got v=%b r=%0d want v=1 r=4", bus32.out_valid, bus32.out_result);
        end
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus32.out_valid !== 1'b0 || bus32.out_result !== 32'h0 || bus32.out_tag !== 5'h0) begin
            bad++; $display("FAIL arst_clear: got v=%b r=%h t=%h want 0 0 0", bus32.out_valid, bus32.out_result, bus32.out_tag);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive32(1'b1, 2'd0, 32'd3, 32'd5, 5'd3);
        #1;
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready: got %b want 1", bus32.in_ready); end
        @(negedge clk);
        drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_stale: got %b want 0", bus32.out_valid); end
        @(negedge clk);
        total++; if (bus32.out_valid !== 1'b1 || bus32.out_result !== 32'd15 || bus32.out_tag !== 5'd3) begin
            bad++; $display("FAIL arst_first_op: got v=%b r=%0d t=%0d want v=1 r=15 t=3", bus32.out_valid, bus32.out_result, bus32.out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [36:0] q32 [$];
        logic [20:0] q16 [$];
        logic [36:0] e32;
        logic [20:0] e16;
        logic [63:0] r;
        for (int cyc = 0; cyc < 410; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                bus32.out_ready = ($urandom_range(0, 3) != 0);
                bus16.out_ready = ($urandom_range(0, 3) != 0);
                drive32(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                        32'(pick(32)), 32'(pick(32)), 5'($urandom));
                bus16.in_valid = ($urandom_range(0, 9) < 7);
                bus16.in_op    = 2'($urandom_range(0, 3));
                bus16.in_src1  = 16'(pick(16));
                bus16.in_src2  = 16'(pick(16));
                bus16.in_tag   = 5'($urandom);
            end else begin
                bus32.out_ready = 1'b1;
                bus16.out_ready = 1'b1;
                bus32.in_valid  = 1'b0;
                bus16.in_valid  = 1'b0;
            end
            #1;
            if (bus32.out_valid && bus32.out_ready) begin
                total++;
                if (q32.size() == 0) begin
                    bad++; $display("FAIL rand32_extra: got r=%h with nothing expected", bus32.out_result);
                end else begin
                    e32 = q32.pop_front();
                    if ({bus32.out_tag, bus32.out_result} !== e32) begin
                        bad++; $display("FAIL rand32: got t=%0d r=%h want t=%0d r=%h", bus32.out_tag, bus32.out_result, e32[36:32], e32[31:0]);
                    end
                end
            end
            if (bus16.out_valid && bus16.out_ready) begin
                total++;
                if (q16.size() == 0) begin
                    bad++; $display("FAIL rand16_extra: got r=%h with nothing expected", bus16.out_result);
                end else begin
                    e16 = q16.pop_front();
                    if ({bus16.out_tag, bus16.out_result} !== e16) begin
                        bad++; $display("FAIL rand16: got t=%0d r=%h want t=%0d r=%h", bus16.out_tag, bus16.out_result, e16[20:16], e16[15:0]);
                    end
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                r = ref_mul(bus32.in_op, 64'(bus32.in_src1), 64'(bus32.in_src2), 32);
                q32.push_back({bus32.in_tag, 32'(r)});
            end
            if (bus16.in_valid && bus16.in_ready) begin
                r = ref_mul(bus16.in_op, 64'(bus16.in_src1), 64'(bus16.in_src2), 16);
                q16.push_back({bus16.in_tag, 16'(r)});
            end
        end
        total++; if (q32.size() != 0) begin bad++; $display("FAIL rand32_undrained: got %0d left want 0", q32.size()); end
        total++; if (q16.size() != 0) begin bad++; $display("FAIL rand16_undrained: got %0d left want 0", q16.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total   = 0;
        bad     = 0;
        clk     = 1'b0;
        reset_n = 1'b0;
        flush   = 1'b0;
        drive32(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        bus32.out_ready = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.in_op     = 2'd0;
        bus16.in_src1   = 16'h0;
        bus16.in_src2   = 16'h0;
        bus16.in_tag    = 5'd0;
        bus16.out_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_corners();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
